// File: rtl/backprop_pkg.sv
// backprop_pkg: shared types and sizes for the backpropagation sequencer
//   state_e : sequencer phases
//   op_e    : micro-operation codes presented to the delta/weight datapath
package backprop_pkg;

    localparam int N_IN_DEF  = 4;
    localparam int N_HID_DEF = 5;
    localparam int N_OUT_DEF = 3;
    localparam int DW        = 10;

    typedef enum logic [2:0] {
        IDLE,
        OUTD,
        HIDD,
        WUPD1,
        WUPD0,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_OUT_DELTA,
        OP_HID_ACC,
        OP_WUPD
    } op_e;

    // Micro-op code issued while sitting in a given phase.
    function automatic op_e phase_op(input state_e s);
        return (s == OUTD)                 ? OP_OUT_DELTA :
               (s == HIDD)                 ? OP_HID_ACC   :
               (s == WUPD1 || s == WUPD0)  ? OP_WUPD      : OP_NOP;
    endfunction

endpackage

// File: rtl/idx2_counter.sv
// idx2_counter: two-level (outer/inner) index counter with run-time limits
//   clk, rst_n           : clock, async active-low reset
//   inc                  : advance on an accepted beat
//   clr                  : force both indices to zero
//   outer_max, inner_max : last valid value of each index
//   outer, inner         : current indices
//   inner_last, all_last : inner at its limit / both at their limits
module idx2_counter #(
    parameter int IW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clr,
    input  logic [IW-1:0] outer_max,
    input  logic [IW-1:0] inner_max,
    output logic [IW-1:0] outer,
    output logic [IW-1:0] inner,
    output logic          inner_last,
    output logic          all_last
);

    logic [IW-1:0] outer_q, outer_d;
    logic [IW-1:0] inner_q, inner_d;

    // >= keeps the counters inside the range even if the limits shrink under them.
    always_comb begin
        inner_last = inner_q >= inner_max;
        all_last   = inner_last && (outer_q >= outer_max);
        inner_d    = clr ? '0 : inc ? (inner_last ? '0 : inner_q + IW'(1)) : inner_q;
        outer_d    = clr ? '0 : (inc && inner_last) ? (all_last ? '0 : outer_q + IW'(1)) : outer_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outer_q <= '0;
            inner_q <= '0;
        end else begin
            outer_q <= outer_d;
            inner_q <= inner_d;
        end
    end

    assign outer = outer_q;
    assign inner = inner_q;

endmodule

// File: rtl/backprop_sequencer.sv
// backprop_sequencer: issues one backprop pass of micro-ops to the shared delta/weight datapath
//   clk, rst_n        : clock, async active-low reset
//   start, train_l0   : begin a pass (IDLE only); train_l0=0 skips the input->hidden update
//   abort             : cancel the current pass
//   dp_valid/dp_ready : micro-op handshake
//   op, layer         : micro-op code and weight layer (1 = hidden->output)
//   idx_i, idx_j      : row / column neuron indices
//   acc_clr           : first HID_ACC beat of a hidden neuron
//   hid_commit        : last HID_ACC beat of a hidden neuron
//   busy, done        : pass in progress / one-cycle completion pulse
//   pass_cnt          : completed passes, saturating at 255
module backprop_sequencer
    import backprop_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_HID = N_HID_DEF,
    parameter int N_OUT = N_OUT_DEF,
    parameter int IW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          train_l0,
    output logic          dp_valid,
    input  logic          dp_ready,
    output logic [1:0]    op,
    output logic          layer,
    output logic [IW-1:0] idx_i,
    output logic [IW-1:0] idx_j,
    output logic          acc_clr,
    output logic          hid_commit,
    output logic          busy,
    output logic          done,
    output logic [7:0]    pass_cnt
);

    state_e        state_q, state_d;
    logic          train_q, train_d;
    logic [7:0]    pass_cnt_q, pass_cnt_d;
    logic          accept, phase_end;
    logic [IW-1:0] outer_max, inner_max;
    logic [IW-1:0] outer, inner;
    logic          inner_last, all_last;

    // One counter serves every phase; OUTD uses only the inner index (k).
    always_comb begin
        outer_max = (state_q == HIDD || state_q == WUPD1) ? IW'(N_HID - 1) :
                    (state_q == WUPD0)                     ? IW'(N_IN - 1)  : '0;
        inner_max = (state_q == WUPD0) ? IW'(N_HID - 1) : IW'(N_OUT - 1);
    end

    idx2_counter #(.IW(IW)) u_idx (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc        (accept && !abort),
        .clr        (abort),
        .outer_max  (outer_max),
        .inner_max  (inner_max),
        .outer      (outer),
        .inner      (inner),
        .inner_last (inner_last),
        .all_last   (all_last)
    );

    always_comb begin
        accept    = dp_valid && dp_ready;
        phase_end = accept && all_last;
        state_d   = state_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = start ? OUTD : IDLE;
                OUTD:    state_d = phase_end ? HIDD : OUTD;
                HIDD:    state_d = phase_end ? WUPD1 : HIDD;
                WUPD1:   state_d = phase_end ? (train_q ? WUPD0 : DONE) : WUPD1;
                WUPD0:   state_d = phase_end ? DONE : WUPD0;
                default: state_d = IDLE;
            endcase
        end
        train_d    = (state_q == IDLE && start) ? train_l0 : train_q;
        // Counted on entry to DONE, so an abort during DONE cannot lose it.
        pass_cnt_d = (state_d == DONE && pass_cnt_q != 8'hFF) ? pass_cnt_q + 8'd1 : pass_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            train_q    <= 1'b0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            train_q    <= train_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    assign dp_valid   = state_q inside {OUTD, HIDD, WUPD1, WUPD0};
    assign op         = phase_op(state_q);
    assign layer      = state_q == WUPD1;
    assign idx_i      = outer;
    assign idx_j      = inner;
    assign acc_clr    = state_q == HIDD && inner == '0;
    assign hid_commit = state_q == HIDD && inner_last;
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign pass_cnt   = pass_cnt_q;

endmodule
